// File: rtl/lane_collision_monitor.sv
// lane_collision_monitor
//
// Sits between the frog position logic and one car-lane row. Each cycle it
// checks whether the frog's column overlaps a car pixel in this lane. It
// charges collisions against a life budget, opens a grace window after each
// non-fatal hit, and raises a sticky game-over flag when the last life is lost.
//
// Ports:
//   clk          in   system clock, all state changes on the rising edge
//   reset        in   synchronous active-low reset (0 = reset)
//   frog_row_en  in   1 = frog currently occupies this lane
//   frog_col     in   frog column 0..15, indexes car_pixels directly
//   car_pixels   in   lane occupancy, 1 = car present
//   hit          out  sticky game-over flag to the car-row stage
//   respawn      out  one-cycle pulse: return the frog to its start position
//   grace        out  1 while post-collision immunity is active
//   lives        out  remaining lives, for the score display
//
// All outputs are registered, so there is no input-to-output combinational path.

module lane_collision_monitor #(
    parameter int LIVES        = 3,   // legal range 1..3
    parameter int GRACE_CYCLES = 64   // legal range 1..255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frog_row_en,
    input  logic [3:0]  frog_col,
    input  logic [15:0] car_pixels,
    output logic        hit,
    output logic        respawn,
    output logic        grace,
    output logic [1:0]  lives
);

    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        GRACE = 2'd1,
        DEAD  = 2'd2
    } state_t;

    state_t      state_q,     state_d;
    logic [1:0]  lives_q,     lives_d;
    logic        hit_q,       hit_d;
    logic        respawn_q,   respawn_d;
    logic        grace_q,     grace_d;
    logic [7:0]  grace_cnt_q, grace_cnt_d;

    logic coll;

    // Column c maps straight onto bit c; columns 0 and 15 need no edge handling.
    assign coll = frog_row_en & car_pixels[frog_col];

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_d     = state_q;
        lives_d     = lives_q;
        hit_d       = hit_q;
        grace_d     = grace_q;
        grace_cnt_d = grace_cnt_q;
        respawn_d   = 1'b0;          // pulse: high only in the cycle it is set

        unique case (state_q)
            PLAY: begin
                if (coll) begin
                    if (lives_q > 2'd1) begin
                        lives_d     = lives_q - 2'd1;
                        respawn_d   = 1'b1;
                        grace_d     = 1'b1;
                        // Counter runs GRACE_CYCLES-1 .. 0, giving GRACE_CYCLES
                        // cycles of grace including the one just entered.
                        grace_cnt_d = 8'(GRACE_CYCLES - 1);
                        state_d     = GRACE;
                    end else begin
                        // Fatal collision: no respawn, the game is over.
                        lives_d = 2'd0;
                        hit_d   = 1'b1;
                        state_d = DEAD;
                    end
                end
            end

            GRACE: begin
                // Collisions are ignored entirely while immune.
                if (grace_cnt_q == 8'd0) begin
                    grace_d = 1'b0;
                    state_d = PLAY;
                end else begin
                    grace_cnt_d = grace_cnt_q - 8'd1;
                end
            end

            DEAD: begin
                // Terminal until reset; all inputs are ignored.
                hit_d   = 1'b1;
                lives_d = 2'd0;
                grace_d = 1'b0;
            end

            default: begin
                state_d = PLAY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= PLAY;
            lives_q     <= 2'(LIVES);
            hit_q       <= 1'b0;
            respawn_q   <= 1'b0;
            grace_q     <= 1'b0;
            grace_cnt_q <= 8'd0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values, independent of statement order.
            state_q     <= state_d;
            lives_q     <= lives_d;
            hit_q       <= hit_d;
            respawn_q   <= respawn_d;
            grace_q     <= grace_d;
            grace_cnt_q <= grace_cnt_d;
        end
    end

    assign hit     = hit_q;
    assign respawn = respawn_q;
    assign grace   = grace_q;
    assign lives   = lives_q;

endmodule

// File: tb/tb_lane_collision_monitor.sv
// Self-checking bench for lane_collision_monitor.
// Two instances share the same stimulus: dut_a uses the default 64-cycle
// grace window, dut_b a 4-cycle window. For every driven cycle, a behavioural
// reference model pushes the expected registered outputs of both instances
// onto a queue. They are popped and compared once the DUT has clocked.

module tb_lane_collision_monitor;

    logic        clk = 1'b0;
    logic        reset;
    logic        frog_row_en;
    logic [3:0]  frog_col;
    logic [15:0] car_pixels;

    logic        hit_a, respawn_a, grace_a;
    logic [1:0]  lives_a;
    logic        hit_b, respawn_b, grace_b;
    logic [1:0]  lives_b;

    always #5 clk = ~clk;

    lane_collision_monitor #(.LIVES(3), .GRACE_CYCLES(64)) dut_a (
        .clk         (clk),
        .reset       (reset),
        .frog_row_en (frog_row_en),
        .frog_col    (frog_col),
        .car_pixels  (car_pixels),
        .hit         (hit_a),
        .respawn     (respawn_a),
        .grace       (grace_a),
        .lives       (lives_a)
    );

    lane_collision_monitor #(.LIVES(3), .GRACE_CYCLES(4)) dut_b (
        .clk         (clk),
        .reset       (reset),
        .frog_row_en (frog_row_en),
        .frog_col    (frog_col),
        .car_pixels  (car_pixels),
        .hit         (hit_b),
        .respawn     (respawn_b),
        .grace       (grace_b),
        .lives       (lives_b)
    );

    typedef struct packed {
        logic       hit;
        logic       respawn;
        logic       grace;
        logic [1:0] lives;
    } out_t;

    out_t exp_q[$];

    int errors = 0;
    int checks = 0;

    // Reference model state, index 0 = dut_a, 1 = dut_b.
    int grace_len [2] = '{64, 4};
    int m_lives   [2];
    int m_left    [2];   // grace cycles still to be shown, 0 = not immune
    bit m_hit     [2];
    bit m_resp    [2];

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic model_step(input int i, input bit rst, input bit coll);
        if (rst) begin
            m_lives[i] = 3; m_left[i] = 0; m_hit[i] = 1'b0; m_resp[i] = 1'b0;
        end else if (m_hit[i]) begin
            m_resp[i] = 1'b0;
        end else if (m_left[i] > 0) begin
            m_left[i]--;
            m_resp[i] = 1'b0;
        end else if (coll) begin
            if (m_lives[i] > 1) begin
                m_lives[i]--;
                m_resp[i] = 1'b1;
                m_left[i] = grace_len[i];
            end else begin
                m_lives[i] = 0;
                m_hit[i]   = 1'b1;
                m_resp[i]  = 1'b0;
            end
        end else begin
            m_resp[i] = 1'b0;
        end
    endtask

    task automatic compare_out(input string who, input out_t e,
                               input logic h, input logic r, input logic g,
                               input logic [1:0] l);
        check({who, ".hit"},     int'(h), int'(e.hit));
        check({who, ".respawn"}, int'(r), int'(e.respawn));
        check({who, ".grace"},   int'(g), int'(e.grace));
        check({who, ".lives"},   int'(l), int'(e.lives));
    endtask

    // One clock cycle: drive inputs, record expectations, clock, compare.
    task automatic step(input bit rst, input bit en, input logic [3:0] col,
                        input logic [15:0] pix);
        bit   coll;
        out_t e;
        reset       = ~rst;
        frog_row_en = en;
        frog_col    = col;
        car_pixels  = pix;
        coll = en & pix[col];
        for (int i = 0; i < 2; i++) begin
            model_step(i, rst, coll);
            e.hit     = m_hit[i];
            e.respawn = m_resp[i];
            e.grace   = (m_left[i] > 0);
            e.lives   = 2'(m_lives[i]);
            exp_q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        if (exp_q.size() < 2) begin
            errors++;
            $display("FAIL scoreboard_underflow observed=%0d expected=2", exp_q.size());
        end else begin
            e = exp_q.pop_front();
            compare_out("a", e, hit_a, respawn_a, grace_a, lives_a);
            e = exp_q.pop_front();
            compare_out("b", e, hit_b, respawn_b, grace_b, lives_b);
        end
    endtask

    initial begin
        int resp_cnt;
        int grace_cnt;
        int resp_mask;

        reset = 1'b0; frog_row_en = 1'b0; frog_col = 4'd0; car_pixels = 16'h0000;
        @(negedge clk);

        // Reset state.
        step(1, 0, 4'd0, 16'h0000);
        check("reset_lives", int'(lives_a), 3);
        check("reset_hit",   int'(hit_a), 0);

        // No cars: 20 quiet cycles.
        resp_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            step(0, 1, 4'd5, 16'h0000);
            resp_cnt += int'(respawn_a);
        end
        check("quiet_respawn_count", resp_cnt, 0);
        check("quiet_lives", int'(lives_a), 3);

        // Single collision at column 2, then 64 grace cycles on dut_a.
        step(1, 0, 4'd0, 16'h0000);
        step(0, 1, 4'd2, 16'b0000000000000100);
        check("single_lives",   int'(lives_a), 2);
        check("single_respawn", int'(respawn_a), 1);
        grace_cnt = int'(grace_a);
        resp_cnt  = 0;
        for (int k = 0; k < 70; k++) begin
            step(0, 1, 4'd5, 16'h0000);
            grace_cnt += int'(grace_a);
            resp_cnt  += int'(respawn_a);
        end
        check("single_grace_len",    grace_cnt, 64);
        check("single_respawn_once", resp_cnt, 0);
        check("single_back_to_play", int'(grace_a), 0);

        // Collision held continuously, observed on dut_b (4-cycle grace).
        step(1, 0, 4'd0, 16'h0000);
        resp_mask = 0;
        for (int k = 1; k <= 14; k++) begin
            step(0, 1, 4'd2, 16'h0004);
            if (respawn_b) resp_mask |= (1 << k);
            if (k == 1)  check("hold_c1_lives",  int'(lives_b), 2);
            if (k == 5)  check("hold_c5_lives",  int'(lives_b), 2);
            if (k == 6)  check("hold_c6_lives",  int'(lives_b), 1);
            if (k == 10) check("hold_c10_lives", int'(lives_b), 1);
            if (k == 11) check("hold_c11_lives", int'(lives_b), 0);
            if (k >= 11) check("hold_hit",       int'(hit_b), 1);
        end
        check("hold_respawn_cycles", resp_mask, (1 << 1) | (1 << 6));

        // DEAD ignores inputs; reset recovers it.
        step(0, 1, 4'd0, 16'hFFFF);
        step(1, 1, 4'd0, 16'hFFFF);
        check("dead_reset_hit",   int'(hit_b), 0);
        check("dead_reset_lives", int'(lives_b), 3);
        check("dead_reset_grace", int'(grace_b), 0);

        // Boundary columns.
        step(1, 0, 4'd0, 16'h0000);
        step(0, 1, 4'd15, 16'h8000);
        check("col15_hit_lives", int'(lives_a), 2);
        step(1, 0, 4'd0, 16'h0000);
        step(0, 1, 4'd0, 16'h0001);
        check("col0_hit_lives", int'(lives_a), 2);
        step(1, 0, 4'd0, 16'h0000);
        step(0, 1, 4'd15, 16'h7FFF);
        check("col15_miss_lives", int'(lives_a), 3);
        step(0, 1, 4'd0, 16'hFFFE);
        check("col0_miss_lives", int'(lives_a), 3);

        // frog_row_en low never collides.
        for (int k = 0; k < 100; k++) step(0, 0, 4'(k), 16'hFFFF);
        check("row_off_lives", int'(lives_a), 3);
        check("row_off_hit",   int'(hit_a), 0);

        // Reset in the middle of a grace window, then a collision counts at once.
        step(0, 1, 4'd7, 16'h0080);
        for (int k = 0; k < 10; k++) step(0, 1, 4'd7, 16'h0000);
        check("midgrace_active", int'(grace_a), 1);
        step(1, 1, 4'd7, 16'h0080);
        check("midgrace_reset_grace", int'(grace_a), 0);
        check("midgrace_reset_lives", int'(lives_a), 3);
        step(0, 1, 4'd7, 16'h0080);
        check("after_reset_coll_lives",   int'(lives_a), 2);
        check("after_reset_coll_respawn", int'(respawn_a), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
